// File: rtl/controle_servo_posicao.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | controle_servo_posicao : servo PWM, width = LARG_MIN + posicao*PASSO     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module controle_servo_posicao #(
   parameter int PERIODO  = 1_000_000,
   parameter int LARG_MIN = 50_000,
   parameter int PASSO    = 7_000,
   parameter int N        = 20
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         liga,
   input  logic [2:0]   posicao,
   output logic         pwm,
   output logic         fim_periodo,
   output logic [2:0]   db_posicao,
   output logic [N-1:0] db_largura
);

   localparam logic [N-1:0] c_ULTIMO   = N'(PERIODO - 1);
   localparam logic [N-1:0] c_LARG_MIN = N'(LARG_MIN);
   localparam logic [N-1:0] c_PASSO    = N'(PASSO);

   logic [N-1:0] r_contador;
   logic         r_pwm;
   logic [2:0]   r_db_posicao;
   logic [N-1:0] r_db_largura;
   logic [N-1:0] w_largura;
   logic         w_fim;

   assign w_largura = c_LARG_MIN + c_PASSO * {{(N-3){1'b0}}, posicao};
   assign w_fim     = liga && (r_contador == c_ULTIMO);

   // Width is only reloaded at the period boundary (or while idle), so the
   // pulse in flight is never altered by a mid-period position change.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_contador   <= '0;
         r_pwm        <= 1'b0;
         r_db_posicao <= 3'd0;
         r_db_largura <= c_LARG_MIN;
      end else if (!liga) begin
         r_contador   <= '0;
         r_pwm        <= 1'b0;
         r_db_posicao <= posicao;
         r_db_largura <= w_largura;
      end else begin
         r_pwm <= (r_contador < r_db_largura);
         if (w_fim) begin
            r_contador   <= '0;
            r_db_posicao <= posicao;
            r_db_largura <= w_largura;
         end else begin
            r_contador <= r_contador + 1'b1;
         end
      end
   end

   assign pwm         = r_pwm;
   assign fim_periodo = w_fim;
   assign db_posicao  = r_db_posicao;
   assign db_largura  = r_db_largura;

endmodule
`default_nettype wire

// File: tb/tb_controle_servo_posicao.sv
`default_nettype none
// Self-checking bench for controle_servo_posicao (PERIODO=100, LARG_MIN=10, PASSO=5).
module tb_controle_servo_posicao;

   localparam int P  = 100;
   localparam int LM = 10;
   localparam int PS = 5;
   localparam int NB = 8;

   logic          clock = 1'b0;
   logic          reset;
   logic          liga;
   logic [2:0]    posicao;
   logic          pwm;
   logic          fim_periodo;
   logic [2:0]    db_posicao;
   logic [NB-1:0] db_largura;

   int total = 0;
   int bad   = 0;

   controle_servo_posicao #(.PERIODO(P), .LARG_MIN(LM), .PASSO(PS), .N(NB)) dut (
      .clock      (clock),
      .reset      (reset),
      .liga       (liga),
      .posicao    (posicao),
      .pwm        (pwm),
      .fim_periodo(fim_periodo),
      .db_posicao (db_posicao),
      .db_largura (db_largura)
   );

   always #5 clock = ~clock;

   typedef struct {
      bit set_pos;
      int pos;
      bit mid_chg;
      int mid_pos;
      int exp_high;
      int exp_dpos;
      int exp_len;
   } vec_t;

   vec_t tbl[21];

   function automatic int larg(input int p);
      return LM + p * PS;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         if (bad <= 30)
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   // Runs until fim_periodo is seen; counts pwm high samples in that window.
   task automatic run_period(input vec_t v, input string name);
      int highs;
      int len;
      bit got;
      highs = 0;
      len   = 0;
      got   = 1'b0;
      if (v.set_pos) posicao = 3'(v.pos);
      for (int i = 0; i < 200 && !got; i++) begin
         tick;
         len++;
         if (len == 1) begin
            chk({name, "_dpos_start"}, int'(db_posicao), v.exp_dpos);
            chk({name, "_dlarg_start"}, int'(db_largura), larg(v.exp_dpos));
         end
         if (v.mid_chg && len == 21) posicao = 3'(v.mid_pos);
         if (pwm) highs++;
         if (fim_periodo) got = 1'b1;
      end
      chk({name, "_fim_seen"}, int'(got), 1);
      chk({name, "_high"}, highs, v.exp_high);
      chk({name, "_len"}, len, v.exp_len);
      chk({name, "_dpos_end"}, int'(db_posicao), v.exp_dpos);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int m_cnt, m_pwm, m_dp, m_dl, m_fim;

      tbl[0] = '{1'b1, 0, 1'b0, 0, 10, 0, P-1};
      tbl[1] = '{1'b1, 0, 1'b0, 0, 10, 0, P};
      tbl[2] = '{1'b1, 7, 1'b0, 0, 45, 7, P};
      tbl[3] = '{1'b0, 7, 1'b0, 0, 45, 7, P};
      tbl[4] = '{1'b1, 2, 1'b1, 5, 20, 2, P};
      tbl[5] = '{1'b0, 0, 1'b0, 0, 35, 5, P};
      for (int k = 0; k < 15; k++) begin
         int p;
         p = (k <= 7) ? k : 14 - k;
         tbl[6+k] = '{1'b1, p, 1'b1, (p + 3) % 8, larg(p), p, P};
      end

      // Reset state
      reset = 1'b1; liga = 1'b0; posicao = 3'd0;
      tick; tick;
      chk("rst_pwm", int'(pwm), 0);
      chk("rst_fim", int'(fim_periodo), 0);
      chk("rst_dpos", int'(db_posicao), 0);
      chk("rst_dlarg", int'(db_largura), LM);

      reset = 1'b0; liga = 1'b1;
      for (int i = 0; i < 21; i++)
         run_period(tbl[i], $sformatf("vec%0d", i));

      // liga drops mid-period, then rises with a new position
      posicao = 3'd3;
      tick;
      chk("off_dpos_latched", int'(db_posicao), 3);
      for (int i = 0; i < 5; i++) tick;
      chk("off_pwm_before", int'(pwm), 1);
      liga = 1'b0;
      tick;
      chk("off_pwm", int'(pwm), 0);
      chk("off_fim", int'(fim_periodo), 0);
      posicao = 3'd4;
      for (int i = 0; i < 4; i++) begin
         tick;
         chk("off_idle_pwm", int'(pwm), 0);
         chk("off_idle_fim", int'(fim_periodo), 0);
         chk("off_track_dpos", int'(db_posicao), 4);
         chk("off_track_dlarg", int'(db_largura), 30);
      end
      liga = 1'b1;
      run_period('{1'b0, 4, 1'b0, 0, 30, 4, P-1}, "on_again");

      // Reset while pulse is high
      posicao = 3'd3;
      tick;
      for (int i = 0; i < 7; i++) tick;
      chk("mrst_pwm_before", int'(pwm), 1);
      chk("mrst_dlarg_before", int'(db_largura), 25);
      reset = 1'b1;
      tick;
      chk("mrst_pwm", int'(pwm), 0);
      chk("mrst_fim", int'(fim_periodo), 0);
      chk("mrst_dpos", int'(db_posicao), 0);
      chk("mrst_dlarg", int'(db_largura), LM);
      reset = 1'b0;
      run_period('{1'b0, 0, 1'b0, 0, 10, 0, P-1}, "mrst_p1");
      run_period('{1'b0, 3, 1'b0, 0, 25, 3, P}, "mrst_p2");

      // Randomized run against a spec-level reference model
      reset = 1'b1;
      tick;
      m_cnt = 0; m_pwm = 0; m_dp = 0; m_dl = LM;
      for (int c = 0; c < 3000; c++) begin
         reset = ($urandom % 250 == 0);
         if ($urandom % 150 == 0) liga = ~liga;
         if ($urandom % 40 == 0) posicao = 3'($urandom % 8);
         #1;
         m_fim = (liga && m_cnt == P - 1) ? 1 : 0;
         chk("rnd_fim", int'(fim_periodo), m_fim);
         if (reset) begin
            m_cnt = 0; m_pwm = 0; m_dp = 0; m_dl = LM;
         end else if (!liga) begin
            m_cnt = 0; m_pwm = 0; m_dp = int'(posicao); m_dl = larg(int'(posicao));
         end else begin
            m_pwm = (m_cnt < m_dl) ? 1 : 0;
            if (m_cnt == P - 1) begin
               m_cnt = 0;
               m_dp  = int'(posicao);
               m_dl  = larg(int'(posicao));
            end else begin
               m_cnt = m_cnt + 1;
            end
         end
         tick;
         chk("rnd_pwm", int'(pwm), m_pwm);
         chk("rnd_dpos", int'(db_posicao), m_dp);
         chk("rnd_dlarg", int'(db_largura), m_dl);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
